// File: rtl/id_stage.sv
// MIPS64r6 decode stage: one-entry output register, 1-cycle latency, one-bubble load-use stall.
// Output register holds bit-stable while out_valid & !out_ready; flush drops held and incoming words.
module id_stage #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      dest,
  output logic            reg_we,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_op,
  output logic [5:0]      shamt,
  output logic            is_64,
  output logic            ovf_trap,
  output logic            use_imm,
  output logic            mem_read,
  output logic            mem_write,
  output logic [1:0]      mem_size,
  output logic            mem_unsigned,
  output logic [1:0]      br_type,
  output logic [1:0]      jump,
  output logic            syscall,
  output logic            eret,
  output logic            mfc0,
  output logic            mtc0,
  output logic            ri
);

  localparam logic [5:0] OP_OTHER0 = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04, OP_BNE    = 6'h05, OP_ADDI  = 6'h08, OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A, OP_SLTIU  = 6'h0B, OP_ORI   = 6'h0D, OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F, OP_Z0     = 6'h10, OP_DADDI = 6'h18, OP_DADDIU = 6'h19;
  localparam logic [5:0] OP_LB     = 6'h20, OP_LW     = 6'h23, OP_LBU   = 6'h24, OP_LWU    = 6'h27;
  localparam logic [5:0] OP_SB     = 6'h28, OP_SW     = 6'h2B, OP_BC    = 6'h32, OP_LD     = 6'h37;
  localparam logic [5:0] OP_SD     = 6'h3F;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_JR    = 6'h08, FN_JALR  = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C, FN_ERET = 6'h18;
  localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUB   = 6'h22, FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR   = 6'h26, FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A, FN_SLTU  = 6'h2B, FN_DADD  = 6'h2C, FN_DADDU = 6'h2D;
  localparam logic [5:0] FN_DSUB = 6'h2E, FN_DSLL  = 6'h38, FN_DSRL  = 6'h3A, FN_DSLL32 = 6'h3C;
  localparam logic [5:0] FN_DSRL32 = 6'h3E;

  localparam logic [4:0] OPR_BAL = 5'h11, RS_MFCZ = 5'h00, RS_MTCZ = 5'h04;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_LUI = 4'd10;

  typedef struct packed {
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dest;
    logic            reg_we;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic [5:0]      shamt;
    logic            is_64;
    logic            ovf_trap;
    logic            use_imm;
    logic            mem_read;
    logic            mem_write;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic [1:0]      br_type;
    logic [1:0]      jump;
    logic            syscall;
    logic            eret;
    logic            mfc0;
    logic            mtc0;
    logic            ri;
  } ctrl_t;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  ctrl_t           r_ctrl;
  ctrl_t           w_dec;
  logic            w_reads_rt;
  logic            w_hazard;
  logic            w_load;

  logic [5:0] w_op, w_fn;
  logic [4:0] w_rs, w_rt, w_rd, w_sa;
  assign w_op = in_inst[31:26];
  assign w_rs = in_inst[25:21];
  assign w_rt = in_inst[20:16];
  assign w_rd = in_inst[15:11];
  assign w_sa = in_inst[10:6];
  assign w_fn = in_inst[5:0];

  // Only bits above 27 of pc+4 feed the jump region; they carry in when pc[27:2] is all ones.
  logic [XLEN-29:0] w_pc_hi;
  assign w_pc_hi = in_pc[XLEN-1:28] + {{(XLEN-29){1'b0}}, &in_pc[27:2]};

  logic [XLEN-1:0] w_imm_sx, w_imm_zx, w_imm_br, w_imm_lui, w_imm_bc, w_imm_j;
  assign w_imm_sx  = {{(XLEN-16){in_inst[15]}}, in_inst[15:0]};
  assign w_imm_zx  = {{(XLEN-16){1'b0}}, in_inst[15:0]};
  assign w_imm_br  = {{(XLEN-18){in_inst[15]}}, in_inst[15:0], 2'b00};
  assign w_imm_lui = {{(XLEN-32){in_inst[15]}}, in_inst[15:0], 16'h0000};
  assign w_imm_bc  = {{(XLEN-28){in_inst[25]}}, in_inst[25:0], 2'b00};
  assign w_imm_j   = {w_pc_hi, in_inst[25:0], 2'b00};

  always_comb begin
    w_dec      = '0;
    w_reads_rt = 1'b0;
    w_dec.rs   = w_rs;
    w_dec.rt   = w_rt;
    case (w_op)
      OP_OTHER0: begin
        case (w_fn)
          FN_SLL, FN_SRL, FN_DSLL, FN_DSRL, FN_DSLL32, FN_DSRL32: begin
            w_dec.dest   = w_rd;
            w_dec.reg_we = 1'b1;
            w_reads_rt   = 1'b1;
            w_dec.alu_op = (w_fn == FN_SLL || w_fn == FN_DSLL || w_fn == FN_DSLL32) ? ALU_SLL : ALU_SRL;
            // funct bit 5 marks the doubleword shifts, bit 2 the "+32" variants
            w_dec.is_64  = w_fn[5];
            w_dec.shamt  = {w_fn[2], w_sa};
          end
          FN_JR:      w_dec.jump = 2'd2;
          FN_JALR: begin
            w_dec.jump   = 2'd2;
            w_dec.dest   = w_rd;
            w_dec.reg_we = 1'b1;
          end
          FN_SYSCALL: w_dec.syscall = 1'b1;
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_DADD, FN_DADDU, FN_DSUB: begin
            w_dec.dest     = w_rd;
            w_dec.reg_we   = 1'b1;
            w_reads_rt     = 1'b1;
            w_dec.is_64    = !(w_fn inside {FN_ADD, FN_ADDU, FN_SUB, FN_SUBU});
            w_dec.ovf_trap = w_fn inside {FN_ADD, FN_SUB, FN_DADD, FN_DSUB};
            case (w_fn)
              FN_SUB, FN_SUBU, FN_DSUB: w_dec.alu_op = ALU_SUB;
              FN_AND:                   w_dec.alu_op = ALU_AND;
              FN_OR:                    w_dec.alu_op = ALU_OR;
              FN_XOR:                   w_dec.alu_op = ALU_XOR;
              FN_NOR:                   w_dec.alu_op = ALU_NOR;
              FN_SLT:                   w_dec.alu_op = ALU_SLT;
              FN_SLTU:                  w_dec.alu_op = ALU_SLTU;
              default:                  w_dec.alu_op = ALU_ADD;
            endcase
          end
          default: w_dec.ri = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        if (w_rt == OPR_BAL) begin
          w_dec.br_type = 2'd3;
          w_dec.dest    = 5'd31;
          w_dec.reg_we  = 1'b1;
          w_dec.imm     = w_imm_br;
        end else begin
          w_dec.ri = 1'b1;
        end
      end
      OP_J, OP_JAL: begin
        w_dec.jump   = 2'd1;
        w_dec.imm    = w_imm_j;
        w_dec.dest   = 5'd31;
        w_dec.reg_we = (w_op == OP_JAL);
      end
      OP_BEQ, OP_BNE: begin
        w_dec.br_type = (w_op == OP_BEQ) ? 2'd1 : 2'd2;
        w_dec.imm     = w_imm_br;
        w_reads_rt    = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_DADDI, OP_DADDIU, OP_SLTI, OP_SLTIU,
      OP_ORI, OP_XORI, OP_LUI: begin
        w_dec.use_imm  = 1'b1;
        w_dec.dest     = w_rt;
        w_dec.reg_we   = 1'b1;
        w_dec.imm      = w_imm_sx;
        w_dec.is_64    = !(w_op inside {OP_ADDI, OP_ADDIU});
        w_dec.ovf_trap = w_op inside {OP_ADDI, OP_DADDI};
        case (w_op)
          OP_SLTI:  w_dec.alu_op = ALU_SLT;
          OP_SLTIU: w_dec.alu_op = ALU_SLTU;
          OP_ORI:   begin w_dec.alu_op = ALU_OR;  w_dec.imm = w_imm_zx;  end
          OP_XORI:  begin w_dec.alu_op = ALU_XOR; w_dec.imm = w_imm_zx;  end
          OP_LUI:   begin w_dec.alu_op = ALU_LUI; w_dec.imm = w_imm_lui; end
          default:  w_dec.alu_op = ALU_ADD;
        endcase
      end
      OP_Z0: begin
        if (in_inst[25]) begin
          w_dec.eret = (w_fn == FN_ERET);
          w_dec.ri   = (w_fn != FN_ERET);
        end else if (w_rs == RS_MFCZ) begin
          w_dec.mfc0   = 1'b1;
          w_dec.dest   = w_rt;
          w_dec.reg_we = 1'b1;
        end else if (w_rs == RS_MTCZ) begin
          w_dec.mtc0 = 1'b1;
          w_reads_rt = 1'b1;
        end else begin
          w_dec.ri = 1'b1;
        end
      end
      OP_LB, OP_LBU, OP_LW, OP_LWU, OP_LD: begin
        w_dec.mem_read     = 1'b1;
        w_dec.mem_size     = (w_op == OP_LD) ? 2'd3 : (w_op inside {OP_LW, OP_LWU}) ? 2'd2 : 2'd0;
        w_dec.mem_unsigned = w_op inside {OP_LBU, OP_LWU};
        w_dec.dest         = w_rt;
        w_dec.reg_we       = 1'b1;
        w_dec.use_imm      = 1'b1;
        w_dec.imm          = w_imm_sx;
        w_dec.is_64        = 1'b1;
      end
      OP_SB, OP_SW, OP_SD: begin
        w_dec.mem_write = 1'b1;
        w_dec.mem_size  = (w_op == OP_SD) ? 2'd3 : (w_op == OP_SW) ? 2'd2 : 2'd0;
        w_dec.use_imm   = 1'b1;
        w_dec.imm       = w_imm_sx;
        w_dec.is_64     = 1'b1;
        w_reads_rt      = 1'b1;
      end
      OP_BC: begin
        w_dec.br_type = 2'd3;
        w_dec.imm     = w_imm_bc;
      end
      default: w_dec.ri = 1'b1;
    endcase
    if (!w_dec.reg_we || w_dec.dest == 5'd0) begin
      w_dec.reg_we = 1'b0;
      w_dec.dest   = 5'd0;
    end
  end

  assign w_hazard = r_valid && r_ctrl.mem_read && (r_ctrl.dest != 5'd0) && in_valid &&
                    ((r_ctrl.dest == w_rs) || ((r_ctrl.dest == w_rt) && w_reads_rt));
  assign w_load   = !r_valid || out_ready;
  assign in_ready = flush || (w_load && !w_hazard);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= RESET_PC;
      r_ctrl  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      if (in_valid && !w_hazard) begin
        r_valid <= 1'b1;
        r_pc    <= in_pc;
        r_ctrl  <= w_dec;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_valid;
  assign pc_out       = r_pc;
  assign rs           = r_ctrl.rs;
  assign rt           = r_ctrl.rt;
  assign dest         = r_ctrl.dest;
  assign reg_we       = r_ctrl.reg_we;
  assign imm          = r_ctrl.imm;
  assign alu_op       = r_ctrl.alu_op;
  assign shamt        = r_ctrl.shamt;
  assign is_64        = r_ctrl.is_64;
  assign ovf_trap     = r_ctrl.ovf_trap;
  assign use_imm      = r_ctrl.use_imm;
  assign mem_read     = r_ctrl.mem_read;
  assign mem_write    = r_ctrl.mem_write;
  assign mem_size     = r_ctrl.mem_size;
  assign mem_unsigned = r_ctrl.mem_unsigned;
  assign br_type      = r_ctrl.br_type;
  assign jump         = r_ctrl.jump;
  assign syscall      = r_ctrl.syscall;
  assign eret         = r_ctrl.eret;
  assign mfc0         = r_ctrl.mfc0;
  assign mtc0         = r_ctrl.mtc0;
  assign ri           = r_ctrl.ri;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode pipeline stage between fetch and execute in the 0dMIPS MIPS64r6 core.
- Accepts fetched instruction words over a valid/ready handshake and decodes them using the mips_define opcode constants.
- Registers the control bundle for execute.
- Detects load-use hazards against the instruction it holds and inserts one bubble; supports flush from branch/exception resolution.

Parameters:
- XLEN, 64, datapath width for immediates and PC.
- RESET_PC, 64'h0, pc_out value at reset.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- pc_out  out  XLEN  PC of held instruction
- rs, rt  out  5 each  source register indices (inst[25:21], inst[20:16])
- dest  out  5  destination: rd for R-type, rt for I-type/loads, 31 for JAL/BAL, 0 when no writeback
- reg_we  out  1  register writeback
- imm  out  XLEN  extended immediate
- alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 LUI
- shamt  out  6  shift amount; DSLL32/DSRL32 add 32
- is_64  out  1  doubleword op; 0 means result is sign-extended from bit 31
- ovf_trap  out  1  ADD/ADDI/SUB/DADD/DADDI/DSUB
- use_imm  out  1  ALU B operand is imm
- mem_read, mem_write  out  1 each
- mem_size  out  2  0 byte, 2 word, 3 dword
- mem_unsigned  out  1  LBU/LWU
- br_type  out  2  0 none, 1 BEQ, 2 BNE, 3 BAL/BC
- jump  out  2  0 none, 1 J/JAL, 2 JR/JALR
- syscall, eret, mfc0, mtc0, ri  out  1 each  special and reserved-instruction flags

Behaviour:
- Reset (asynchronous, immediate): out_valid=0, pc_out=RESET_PC; all other registered outputs 0 (alu_op=ADD, dest=0, every flag clear).
- Latency: an instruction accepted on cycle N appears with out_valid=1 on cycle N+1.
- Output register updates only when it is empty or out_ready=1. While out_valid=1 and out_ready=0, all outputs hold bit-stable.
- in_ready = flush | ((!out_valid | out_ready) & !hazard).
- hazard = out_valid & mem_read & dest!=0 & in_valid & (dest==rs_new | (dest==rt_new & new instruction reads rt)).
  - "Reads rt" is true for R-type, BEQ/BNE, stores and MTC0.
- On hazard with out_ready=1: the held load moves to execute and the register loads a bubble (out_valid=0). The following cycle the same instruction is accepted (one-bubble stall).
- flush has priority over everything: out_valid←0 next edge; in_ready=1; any instruction presented that cycle is consumed and dropped.
- Immediate extension:
  - Sign-extend for ADDI/ADDIU/DADDI/DADDIU/SLTI/SLTIU, loads, stores and branches (branches: offset<<2).
  - Zero-extend for ORI/XORI.
  - LUI: imm = sign-extended {inst[15:0],16'h0}.
  - J/JAL: imm = {pc_out[63:28], inst[25:0], 2'b00} computed from in_pc+4.
  - BC: imm = sign-extended inst[25:0]<<2.
- Decode keys:
  - OP_OTHER0 uses funct (SLL, SRL, JR, JALR, ADD..SLTU, DADD/DADDU/DSUB, DSLL/DSRL/32, SYSCALL).
  - OP_REGIMM with rt=OPR_BAL gives BAL.
  - OP_Z0: rs=MFCZ/MTCZ; inst[25]=1 with funct=0x18 gives ERET.
  - JR decodes as JALR with rd=0 (reg_we=0).
- Any unlisted opcode/funct/rt/rs combination: ri=1, reg_we=0, mem_read=mem_write=0, br_type=0, jump=0; out_valid still 1 so execute raises the exception.
- Writes to register 0 force reg_we=0 and dest=0.
- SYSCALL, ERET, MTC0: reg_we=0. MFC0: dest=rt, reg_we=1.
- Reset mid-handshake: in_ready reflects reset state immediately; no instruction is retained.

Test Plan:
- ADDIU 0x2408FFFF, then ORI 0x3408FFFF (out_ready=1) → cycle+1: alu_op=0, use_imm=1, imm=64'hFFFF_FFFF_FFFF_FFFF, dest=8, reg_we=1. Next cycle: alu_op=3, imm=64'h0000_0000_0000_FFFF.
- LW 0x8D090000 followed by ADDU 0x01295021 → in_ready=0 for one cycle, one bubble (out_valid=0), then ADDU appears with dest=10; no instruction lost or duplicated.
- out_ready=0 for 3 cycles with DSLL32 0x0008403C held → outputs stable, in_ready=0; shamt=32, is_64=1. Release: next instruction flows.
- flush asserted while holding BEQ 0x11090004 and presenting LB → out_valid=0 next cycle, LB never appears; br_type of BEQ never reaches execute.
- Reserved 0x7C000000, then SYSCALL 0x0000000C, then ERET 0x42000018 → ri=1 (reg_we=0), then syscall=1, then eret=1, each valid one cycle.
- Assert reset mid-stream with out_valid=1 → out_valid=0 and pc_out=RESET_PC immediately, before the next clock edge.
